// File: rtl/reg_trigger_qualifier_pkg.sv
// reg_trigger_qualifier_pkg: shared state encoding, register map and helpers
// Revision: 1.0
`default_nettype none

package reg_trigger_qualifier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_COUNTING = 3'd2,
    ST_FIRE     = 3'd3,
    ST_HOLDOFF  = 3'd4
  } qual_state_t;

  localparam logic [5:0]  DEFAULT_ADDR   = 6'd54;
  localparam logic [15:0] REG_LEN        = 16'd9;

  localparam logic [15:0] OFF_CTRL       = 16'd0;
  localparam logic [15:0] OFF_THRESH     = 16'd1;
  localparam logic [15:0] OFF_WINDOW_LO  = 16'd2;
  localparam logic [15:0] OFF_WINDOW_HI  = 16'd3;
  localparam logic [15:0] OFF_HOLDOFF_LO = 16'd4;
  localparam logic [15:0] OFF_HOLDOFF_HI = 16'd5;
  localparam logic [15:0] OFF_PULSE      = 16'd6;
  localparam logic [15:0] OFF_FIRECNT_LO = 16'd7;
  localparam logic [15:0] OFF_FIRECNT_HI = 16'd8;

  function automatic logic [7:0] at_least_one(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_trigger_qualifier_fsm.sv
// trig_qual_fsm: edge detector, qualification FSM and window/holdoff/pulse counters
// Revision: 1.0
`default_nettype none

module trig_qual_fsm
  import reg_trigger_qualifier_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  threshold,
  input  logic [15:0] window,
  input  logic [15:0] holdoff,
  input  logic [7:0]  pulse_width,
  input  logic        trig_i,
  output logic        trig_o,
  output logic        fire_start
);

  qual_state_t state, state_next;
  logic        trig_q;
  logic [7:0]  match_cnt, match_cnt_next;
  logic [15:0] win_cnt, win_cnt_next;
  logic [15:0] hold_cnt, hold_cnt_next;
  logic [7:0]  pulse_cnt, pulse_cnt_next;
  logic        trig_edge;
  logic [7:0]  thr_eff;
  logic [7:0]  pw_eff;
  logic [7:0]  match_inc;
  logic        win_expire;

  assign trig_edge = trig_i & ~trig_q;
  assign thr_eff   = at_least_one(threshold);
  assign pw_eff    = at_least_one(pulse_width);
  assign match_inc = (trig_edge && match_cnt != 8'hFF) ? match_cnt + 8'd1 : match_cnt;
  // win_cnt counts cycles since the first edge; the last in-window cycle is window-1
  assign win_expire = (window != 16'd0) && (({1'b0, win_cnt} + 17'd1) >= {1'b0, window});

  assign trig_o     = (state == ST_FIRE);
  assign fire_start = (state != ST_FIRE) && (state_next == ST_FIRE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      trig_q    <= 1'b0;
      match_cnt <= 8'd0;
      win_cnt   <= 16'd0;
      hold_cnt  <= 16'd0;
      pulse_cnt <= 8'd0;
    end else begin
      state     <= state_next;
      trig_q    <= trig_i;
      match_cnt <= match_cnt_next;
      win_cnt   <= win_cnt_next;
      hold_cnt  <= hold_cnt_next;
      pulse_cnt <= pulse_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    match_cnt_next = match_cnt;
    win_cnt_next   = win_cnt;
    hold_cnt_next  = hold_cnt;
    pulse_cnt_next = pulse_cnt;
    if (!enable) begin
      state_next     = ST_IDLE;
      match_cnt_next = 8'd0;
      win_cnt_next   = 16'd0;
      hold_cnt_next  = 16'd0;
      pulse_cnt_next = 8'd0;
    end else begin
      case (state)
        ST_IDLE: state_next = ST_ARMED;
        ST_ARMED: begin
          if (trig_edge) begin
            if (thr_eff <= 8'd1) begin
              state_next     = ST_FIRE;
              pulse_cnt_next = 8'd1;
            end else begin
              state_next     = ST_COUNTING;
              match_cnt_next = 8'd1;
              win_cnt_next   = 16'd1;
            end
          end
        end
        ST_COUNTING: begin
          match_cnt_next = match_inc;
          if (win_cnt != 16'hFFFF) win_cnt_next = win_cnt + 16'd1;
          // an edge in the expiry cycle still gets its chance to qualify
          if (match_inc >= thr_eff) begin
            state_next     = ST_FIRE;
            pulse_cnt_next = 8'd1;
            match_cnt_next = 8'd0;
            win_cnt_next   = 16'd0;
          end else if (win_expire) begin
            state_next     = ST_ARMED;
            match_cnt_next = 8'd0;
            win_cnt_next   = 16'd0;
          end
        end
        ST_FIRE: begin
          if (pulse_cnt >= pw_eff) begin
            pulse_cnt_next = 8'd0;
            if (holdoff == 16'd0) begin
              state_next = ST_ARMED;
            end else begin
              state_next    = ST_HOLDOFF;
              hold_cnt_next = 16'd1;
            end
          end else begin
            pulse_cnt_next = pulse_cnt + 8'd1;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt >= holdoff) begin
            state_next    = ST_ARMED;
            hold_cnt_next = 16'd0;
          end else begin
            hold_cnt_next = hold_cnt + 16'd1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_trigger_qualifier.sv
// reg_trigger_qualifier: register-bus wrapper around the SAD trigger qualifier FSM
// Revision: 1.0
`default_nettype none

module reg_trigger_qualifier
  import reg_trigger_qualifier_pkg::*;
#(
  parameter logic [5:0] ADDR = DEFAULT_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  reg_address,
  input  logic [15:0] reg_bytecnt,
  input  logic [7:0]  reg_datai,
  output logic [7:0]  reg_datao,
  input  logic        reg_read,
  input  logic        reg_write,
  input  logic        reg_addrvalid,
  input  logic [5:0]  reg_hypaddress,
  output logic [15:0] reg_hyplen,
  input  logic        trig_i,
  output logic        trig_o
);

  logic        enable;
  logic [7:0]  threshold;
  logic [15:0] window;
  logic [15:0] holdoff;
  logic [7:0]  pulse_width;
  logic [15:0] fire_count;
  logic        addressed;
  logic        wr_en;
  logic        clear_count;
  logic        fire_start;
  logic [7:0]  read_byte;

  assign addressed   = (reg_address == ADDR);
  assign wr_en       = reg_write & reg_addrvalid & addressed;
  assign clear_count = wr_en && (reg_bytecnt == OFF_CTRL) && reg_datai[1];
  assign reg_hyplen  = (reg_hypaddress == ADDR) ? REG_LEN : 16'd0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable      <= 1'b0;
      threshold   <= 8'd1;
      window      <= 16'd0;
      holdoff     <= 16'd0;
      pulse_width <= 8'd1;
      fire_count  <= 16'd0;
    end else begin
      if (wr_en) begin
        case (reg_bytecnt)
          OFF_CTRL:       enable         <= reg_datai[0];
          OFF_THRESH:     threshold      <= reg_datai;
          OFF_WINDOW_LO:  window[7:0]    <= reg_datai;
          OFF_WINDOW_HI:  window[15:8]   <= reg_datai;
          OFF_HOLDOFF_LO: holdoff[7:0]   <= reg_datai;
          OFF_HOLDOFF_HI: holdoff[15:8]  <= reg_datai;
          OFF_PULSE:      pulse_width    <= reg_datai;
          default: ;
        endcase
      end
      // a clear issued in the same cycle as a fire wins
      if (clear_count)
        fire_count <= 16'd0;
      else if (fire_start && fire_count != 16'hFFFF)
        fire_count <= fire_count + 16'd1;
    end
  end

  always_comb begin
    read_byte = 8'd0;
    case (reg_bytecnt)
      OFF_CTRL:       read_byte = {7'd0, enable};
      OFF_THRESH:     read_byte = threshold;
      OFF_WINDOW_LO:  read_byte = window[7:0];
      OFF_WINDOW_HI:  read_byte = window[15:8];
      OFF_HOLDOFF_LO: read_byte = holdoff[7:0];
      OFF_HOLDOFF_HI: read_byte = holdoff[15:8];
      OFF_PULSE:      read_byte = pulse_width;
      OFF_FIRECNT_LO: read_byte = fire_count[7:0];
      OFF_FIRECNT_HI: read_byte = fire_count[15:8];
      default:        read_byte = 8'd0;
    endcase
  end

  assign reg_datao = (addressed && reg_read) ? read_byte : 8'd0;

  trig_qual_fsm u_fsm (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .threshold   (threshold),
    .window      (window),
    .holdoff     (holdoff),
    .pulse_width (pulse_width),
    .trig_i      (trig_i),
    .trig_o      (trig_o),
    .fire_start  (fire_start)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_trigger_qualifier.sv
// tb_reg_trigger_qualifier: directed self-checking bench for reg_trigger_qualifier
// Revision: 1.0
`default_nettype none

module tb_reg_trigger_qualifier;

  localparam logic [5:0] ADDR = 6'd54;

  logic        clk;
  logic        reset_n;
  logic [5:0]  reg_address;
  logic [15:0] reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;
  logic [5:0]  reg_hypaddress;
  logic [15:0] reg_hyplen;
  logic        trig_i;
  logic        trig_o;

  int passed;
  int total;

  reg_trigger_qualifier #(.ADDR(ADDR)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .reg_datai      (reg_datai),
    .reg_datao      (reg_datao),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_addrvalid  (reg_addrvalid),
    .reg_hypaddress (reg_hypaddress),
    .reg_hyplen     (reg_hyplen),
    .trig_i         (trig_i),
    .trig_o         (trig_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] idx, input logic [7:0] d);
    reg_address   = ADDR;
    reg_bytecnt   = idx;
    reg_datai     = d;
    reg_write     = 1'b1;
    reg_addrvalid = 1'b1;
    tick();
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  task automatic rd(input logic [15:0] idx, output logic [7:0] d);
    reg_address   = ADDR;
    reg_bytecnt   = idx;
    reg_read      = 1'b1;
    reg_addrvalid = 1'b1;
    #1;
    d             = reg_datao;
    reg_read      = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  task automatic rd_all(output logic [71:0] v);
    logic [7:0] b;
    v = '0;
    for (int i = 0; i < 9; i++) begin
      rd(16'(i), b);
      v[i*8 +: 8] = b;
    end
  endtask

  task automatic rd_count(output logic [15:0] c);
    logic [7:0] lo, hi;
    rd(16'd7, lo);
    rd(16'd8, hi);
    c = {hi, lo};
  endtask

  // Disable, program, re-enable, then wait for IDLE->ARMED
  task automatic configure(input logic [7:0] thr, input logic [15:0] win,
                           input logic [15:0] hold, input logic [7:0] pw);
    wr(16'd0, 8'h00);
    wr(16'd1, thr);
    wr(16'd2, win[7:0]);
    wr(16'd3, win[15:8]);
    wr(16'd4, hold[7:0]);
    wr(16'd5, hold[15:8]);
    wr(16'd6, pw);
    wr(16'd0, 8'h01);
    tick();
    tick();
  endtask

  // obs[i] is trig_o sampled just after the edge that sampled trig_i = rises[i]
  task automatic drive_seq(input logic [63:0] rises, input int n, output logic [63:0] obs);
    obs = '0;
    for (int i = 0; i < n; i++) begin
      trig_i = rises[i];
      tick();
      obs[i] = trig_o;
    end
    trig_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [71:0] v;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    total++;
    if (trig_o !== 1'b0) $display("FAIL reset_trig_o got=%b exp=0", trig_o);
    else passed++;
    reg_address = ADDR; reg_bytecnt = 16'd1; reg_read = 1'b0; #1;
    total++;
    if (reg_datao !== 8'h00) $display("FAIL reset_datao_noread got=%h exp=00", reg_datao);
    else passed++;
    rd_all(v);
    total++;
    if (v !== 72'h000001000000000100) $display("FAIL reset_regs got=%h exp=000001000000000100", v);
    else passed++;
  endtask

  task automatic test_single_pulse();
    logic [63:0] obs;
    logic [15:0] c;
    configure(8'd1, 16'd0, 16'd0, 8'd4);
    drive_seq(64'h4, 10, obs);
    total++;
    if (obs !== 64'h3C) $display("FAIL single_pulse got=%h exp=%h", obs, 64'h3C);
    else passed++;
    rd_count(c);
    total++;
    if (c !== 16'd1) $display("FAIL single_firecount got=%h exp=0001", c);
    else passed++;
  endtask

  task automatic test_window();
    logic [63:0] obs;
    configure(8'd3, 16'd10, 16'd0, 8'd1);
    drive_seq((64'd1 << 0) | (64'd1 << 4) | (64'd1 << 9), 14, obs);
    total++;
    if (obs !== (64'd1 << 9)) $display("FAIL window_inside got=%h exp=%h", obs, 64'd1 << 9);
    else passed++;
    // rise at 10 is outside the window and must restart at count=1
    drive_seq((64'd1 << 0) | (64'd1 << 4) | (64'd1 << 10) | (64'd1 << 14) | (64'd1 << 19), 24, obs);
    total++;
    if (obs !== (64'd1 << 19)) $display("FAIL window_boundary got=%h exp=%h", obs, 64'd1 << 19);
    else passed++;
  endtask

  task automatic test_holdoff();
    logic [63:0] obs;
    logic [63:0] rises;
    configure(8'd2, 16'd0, 16'd20, 8'd1);
    rises = '0;
    for (int k = 0; k < 8; k++) rises[k*5] = 1'b1;
    drive_seq(rises, 40, obs);
    total++;
    if (obs !== ((64'd1 << 5) | (64'd1 << 35)))
      $display("FAIL holdoff got=%h exp=%h", obs, (64'd1 << 5) | (64'd1 << 35));
    else passed++;
  endtask

  task automatic test_disable();
    logic [63:0] obs;
    configure(8'd3, 16'd0, 16'd0, 8'd8);
    drive_seq((64'd1 << 0) | (64'd1 << 4), 6, obs);
    total++;
    if (obs !== 64'd0) $display("FAIL disable_partial got=%h exp=0", obs);
    else passed++;
    wr(16'd0, 8'h00);
    tick();
    wr(16'd0, 8'h01);
    tick();
    tick();
    drive_seq((64'd1 << 0) | (64'd1 << 4) | (64'd1 << 8), 18, obs);
    total++;
    if (obs !== 64'hFF00) $display("FAIL disable_rematch got=%h exp=%h", obs, 64'hFF00);
    else passed++;
    wr(16'd1, 8'd1);
    drive_seq(64'd1, 3, obs);
    total++;
    if (obs !== 64'h7) $display("FAIL disable_prefire got=%h exp=7", obs);
    else passed++;
    wr(16'd0, 8'h00);
    tick();
    total++;
    if (trig_o !== 1'b0) $display("FAIL disable_midfire got=%b exp=0", trig_o);
    else passed++;
  endtask

  task automatic test_regbus();
    logic [7:0]  lo, hi, b;
    logic [63:0] obs;
    wr(16'd2, 8'h34);
    wr(16'd3, 8'h12);
    rd(16'd2, lo);
    rd(16'd3, hi);
    total++;
    if ({hi, lo} !== 16'h1234) $display("FAIL reg_window_rb got=%h exp=1234", {hi, lo});
    else passed++;
    reg_hypaddress = ADDR; #1;
    total++;
    if (reg_hyplen !== 16'd9) $display("FAIL hyplen_at_addr got=%0d exp=9", reg_hyplen);
    else passed++;
    reg_hypaddress = 6'd53; #1;
    total++;
    if (reg_hyplen !== 16'd0) $display("FAIL hyplen_other got=%0d exp=0", reg_hyplen);
    else passed++;
    wr(16'd1, 8'h05);
    reg_address = 6'd53; reg_bytecnt = 16'd1; reg_datai = 8'h77;
    reg_write = 1'b1; reg_addrvalid = 1'b1;
    tick();
    reg_write = 1'b0;
    reg_read = 1'b1; #1;
    total++;
    if (reg_datao !== 8'h00) $display("FAIL datao_other_addr got=%h exp=00", reg_datao);
    else passed++;
    reg_read = 1'b0; reg_addrvalid = 1'b0;
    rd(16'd1, b);
    total++;
    if (b !== 8'h05) $display("FAIL write_other_addr got=%h exp=05", b);
    else passed++;
    wr(16'd9, 8'hAB);
    rd(16'd9, b);
    total++;
    if (b !== 8'h00) $display("FAIL byte9 got=%h exp=00", b);
    else passed++;
    configure(8'd1, 16'd0, 16'd0, 8'd0);
    drive_seq(64'h2, 5, obs);
    total++;
    if (obs !== 64'h2) $display("FAIL pulse_zero got=%h exp=2", obs);
    else passed++;
  endtask

  task automatic test_threshold_lower();
    logic [63:0] obs;
    configure(8'd5, 16'd0, 16'd0, 8'd1);
    drive_seq((64'd1 << 0) | (64'd1 << 2) | (64'd1 << 4), 6, obs);
    total++;
    if (obs !== 64'd0) $display("FAIL thr_lower_pre got=%h exp=0", obs);
    else passed++;
    wr(16'd1, 8'd2);
    tick();
    total++;
    if (trig_o !== 1'b1) $display("FAIL thr_lower_fire got=%b exp=1", trig_o);
    else passed++;
  endtask

  task automatic test_saturate_and_clear();
    logic [63:0] obs;
    logic [15:0] c;
    configure(8'd1, 16'd0, 16'd0, 8'd1);
    dut.fire_count = 16'hFFFE;
    drive_seq((64'd1 << 0) | (64'd1 << 2) | (64'd1 << 4), 6, obs);
    total++;
    if (obs !== 64'h15) $display("FAIL sat_pulses got=%h exp=15", obs);
    else passed++;
    rd_count(c);
    total++;
    if (c !== 16'hFFFF) $display("FAIL sat_firecount got=%h exp=ffff", c);
    else passed++;
    trig_i = 1'b1;
    wr(16'd0, 8'h03);
    trig_i = 1'b0;
    total++;
    if (trig_o !== 1'b1) $display("FAIL clear_fire_pulse got=%b exp=1", trig_o);
    else passed++;
    rd_count(c);
    total++;
    if (c !== 16'h0000) $display("FAIL clear_with_fire got=%h exp=0000", c);
    else passed++;
    tick();
  endtask

  task automatic test_reset_midfire();
    logic [71:0] v;
    configure(8'd1, 16'h1234, 16'd5, 8'd8);
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    reset_n = 1'b0;
    tick();
    total++;
    if (trig_o !== 1'b0) $display("FAIL reset_midfire got=%b exp=0", trig_o);
    else passed++;
    reset_n = 1'b1;
    rd_all(v);
    total++;
    if (v !== 72'h000001000000000100) $display("FAIL reset_midfire_regs got=%h exp=000001000000000100", v);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    reset_n = 1'b0;
    reg_address = 6'd0;
    reg_bytecnt = 16'd0;
    reg_datai = 8'd0;
    reg_read = 1'b0;
    reg_write = 1'b0;
    reg_addrvalid = 1'b0;
    reg_hypaddress = 6'd0;
    trig_i = 1'b0;
    test_reset();
    test_single_pulse();
    test_window();
    test_holdoff();
    test_disable();
    test_regbus();
    test_threshold_lower();
    test_saturate_and_clear();
    test_reset_midfire();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
